top_module_pipe: RTL and testbench

// Top level of a 5-stage (IF/ID/EX/MEM/WB) in-order RV32I-subset pipelined core with on-chip
// 128-word instruction memory (IMEM) and 128-word data memory (DMEM). Program is loaded word by

---
 rtl/top_module_pipe.sv | 112 +++++++++++
 tb/tb_top_module_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_module_pipe.sv
// top_module_pipe: 5-stage RV32I-subset pipelined core with on-chip 128-word IMEM and DMEM
module top_module_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        resetpc,
  input  logic        we0,
  input  logic [8:0]  wr_addr0,
  input  logic [31:0] wr_din0
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LW = 7'h03, OP_SW = 7'h23, OP_IMM = 7'h13, OP_R = 7'h33;
  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:127];
  logic [31:0] rf [0:31];
  logic [31:0] pc;
  logic        fd_v, de_v, em_we, em_ld, em_st, mw_we;
  logic [31:0] fd_pc, fd_ir, de_pc, de_ir, de_a, de_b, em_res, em_sd, mw_val;
  logic [4:0]  em_rd, mw_rd;
  logic        unused;
  assign unused = ^wr_addr0[1:0];
  logic [6:0]  id_op;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use1, id_use2, stall;
  logic [31:0] id_a, id_b;
  assign id_op  = fd_ir[6:0];
  assign id_rs1 = fd_ir[19:15];
  assign id_rs2 = fd_ir[24:20];
  assign id_a = (mw_we && mw_rd == id_rs1) ? mw_val : rf[id_rs1];
  assign id_b = (mw_we && mw_rd == id_rs2) ? mw_val : rf[id_rs2];
  assign id_use1 = fd_v && id_op != OP_LUI && id_op != OP_AUIPC && id_op != OP_JAL;
  assign id_use2 = fd_v && (id_op == OP_BR || id_op == OP_SW || id_op == OP_R);
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, fa, fb, b2, sra, alu, tgt, res;
  logic        eq, lt, ltu, brc, taken, wr;
  assign ex_op  = de_ir[6:0];
  assign ex_f3  = de_ir[14:12];
  assign ex_rd  = de_ir[11:7];
  assign ex_rs1 = de_ir[19:15];
  assign ex_rs2 = de_ir[24:20];
  assign imm_i = {{20{de_ir[31]}}, de_ir[31:20]};
  assign imm_s = {{20{de_ir[31]}}, de_ir[31:25], de_ir[11:7]};
  assign imm_b = {{19{de_ir[31]}}, de_ir[31], de_ir[7], de_ir[30:25], de_ir[11:8], 1'b0};
  assign imm_u = {de_ir[31:12], 12'b0};
  assign imm_j = {{11{de_ir[31]}}, de_ir[31], de_ir[19:12], de_ir[20], de_ir[30:21], 1'b0};
  // loads never need the EX/MEM path: the load-use stall guarantees the value comes from MEM/WB
  assign stall = de_v && ex_op == OP_LW && ex_rd != 5'd0 &&
                 ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
  assign fa = (em_we && em_rd == ex_rs1) ? em_res : (mw_we && mw_rd == ex_rs1) ? mw_val : de_a;
  assign fb = (em_we && em_rd == ex_rs2) ? em_res : (mw_we && mw_rd == ex_rs2) ? mw_val : de_b;
  assign b2  = ex_op == OP_R ? fb : imm_i;
  assign sra = $signed(fa) >>> b2[4:0];
  assign alu = ex_f3 == 3'd0 ? (ex_op == OP_R && de_ir[30] ? fa - b2 : fa + b2) :
               ex_f3 == 3'd1 ? fa << b2[4:0] :
               ex_f3 == 3'd2 ? {31'b0, $signed(fa) < $signed(b2)} :
               ex_f3 == 3'd3 ? {31'b0, fa < b2} :
               ex_f3 == 3'd4 ? fa ^ b2 :
               ex_f3 == 3'd5 ? (de_ir[30] ? sra : fa >> b2[4:0]) :
               ex_f3 == 3'd6 ? fa | b2 : fa & b2;
  assign eq  = fa == fb;
  assign lt  = $signed(fa) < $signed(fb);
  assign ltu = fa < fb;
  assign brc = ex_f3 == 3'd0 ? eq : ex_f3 == 3'd1 ? !eq : ex_f3 == 3'd4 ? lt :
               ex_f3 == 3'd5 ? !lt : ex_f3 == 3'd6 ? ltu : ex_f3 == 3'd7 ? !ltu : 1'b0;
  assign taken = de_v && (ex_op == OP_JAL || ex_op == OP_JALR || (ex_op == OP_BR && brc));
  assign tgt = (ex_op == OP_JALR ? (fa + imm_i) & ~32'd1 :
                de_pc + (ex_op == OP_JAL ? imm_j : imm_b)) & 32'h1ff;
  assign res = ex_op == OP_LUI ? imm_u :
               ex_op == OP_AUIPC ? de_pc + imm_u :
               (ex_op == OP_JAL || ex_op == OP_JALR) ? de_pc + 32'd4 :
               ex_op == OP_LW ? fa + imm_i :
               ex_op == OP_SW ? fa + imm_s : alu;
  assign wr = ex_op == OP_LUI || ex_op == OP_AUIPC || ex_op == OP_JAL || ex_op == OP_JALR ||
              ex_op == OP_LW || ex_op == OP_IMM || ex_op == OP_R;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      fd_v  <= 1'b0;
      de_v  <= 1'b0;
      em_we <= 1'b0;
      em_ld <= 1'b0;
      em_st <= 1'b0;
      mw_we <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc   <= !resetpc ? '0 : taken ? tgt : stall ? pc : (pc + 32'd4) & 32'h1ff;
      fd_v <= !taken && (stall ? fd_v : resetpc);
      if (!stall) begin
        fd_pc <= pc;
        fd_ir <= imem[pc[8:2]];
      end
      de_v   <= fd_v && !taken && !stall;
      de_pc  <= fd_pc;
      de_ir  <= fd_ir;
      de_a   <= id_a;
      de_b   <= id_b;
      em_we  <= de_v && wr && ex_rd != 5'd0;
      em_ld  <= de_v && ex_op == OP_LW;
      em_st  <= de_v && ex_op == OP_SW;
      em_rd  <= ex_rd;
      em_res <= res;
      em_sd  <= fb;
      mw_we  <= em_we;
      mw_rd  <= em_rd;
      mw_val <= em_ld ? dmem[em_res[8:2]] : em_res;
      if (mw_we) rf[mw_rd] <= mw_val;
    end
  end
  always_ff @(posedge clk) if (we0) imem[wr_addr0[8:2]] <= wr_din0;
  always_ff @(posedge clk) if (!reset && em_st) dmem[em_res[8:2]] <= em_sd;
endmodule

// File: tb/tb_top_module_pipe.sv
// tb_top_module_pipe: directed programs plus random forward-branching programs checked against an ISA-level model
module tb_top_module_pipe;
  logic        clk = 1'b0, reset, resetpc, we0;
  logic [8:0]  wr_addr0;
  logic [31:0] wr_din0;
  int          total = 0, bad = 0;
  logic [31:0] prog [128];
  logic [31:0] mrf [32];
  logic [31:0] mdm [128];
  bit          known [128];
  int          bf [6] = '{0, 1, 4, 5, 6, 7};
  top_module_pipe dut (.clk(clk), .reset(reset), .resetpc(resetpc), .we0(we0),
                       .wr_addr0(wr_addr0), .wr_din0(wr_din0));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(int n);
    we0 = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_addr0 = 9'(4 * i);
      wr_din0  = prog[i];
      @(negedge clk);
    end
    we0 = 1'b0;
  endtask
  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] es(int imm, int rs1, int rs2);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs1, int rs2, int f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] alu_f(logic [2:0] f3, logic [31:0] a, logic [31:0] b, logic alt);
    logic signed [31:0] s;
    s = a;
    s = s >>> b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? s : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction
  function automatic bit take(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  // instruction-at-a-time architectural model, run until the halt self-loop is reached
  task automatic iss(int halt);
    logic [31:0] p, ir, a, b, w, nx, ea, iv;
    int ii, isv, ib, ij, steps;
    logic [4:0] rd;
    bit wr;
    for (int r = 0; r < 32; r++) mrf[r] = '0;
    p = '0;
    steps = 0;
    while (p != 32'(halt * 4) && steps < 5000) begin
      ir = prog[p[8:2]];
      a = mrf[ir[19:15]];
      b = mrf[ir[24:20]];
      rd = ir[11:7];
      ii = $signed(ir[31:20]);
      iv = ii;
      isv = $signed({ir[31:25], ir[11:7]});
      ib = $signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      ij = $signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      nx = p + 4;
      wr = 1'b1;
      w = '0;
      case (ir[6:0])
        7'h37: w = {ir[31:12], 12'b0};
        7'h17: w = p + {ir[31:12], 12'b0};
        7'h6f: begin w = p + 4; nx = p + ij; end
        7'h67: begin w = p + 4; nx = (a + iv) & ~32'd1; end
        7'h63: begin wr = 1'b0; if (take(ir[14:12], a, b)) nx = p + ib; end
        7'h03: begin ea = a + iv; w = mdm[ea[8:2]]; end
        7'h23: begin wr = 1'b0; ea = a + isv; mdm[ea[8:2]] = b; known[ea[8:2]] = 1'b1; end
        7'h13: w = alu_f(ir[14:12], a, iv, ir[14:12] == 3'd5 && ir[30]);
        7'h33: w = alu_f(ir[14:12], a, b, ir[30]);
        default: wr = 1'b0;
      endcase
      if (wr && rd != 5'd0) mrf[rd] = w;
      p = nx & 32'h1ff;
      steps++;
    end
  endtask
  task automatic gen();
    int c, rd, r1, r2, f3, k, imm;
    for (int i = 0; i < 16; i++) prog[i] = es(4 * i, 0, 0);
    for (int i = 16; i < 76; i++) begin
      c = $urandom_range(0, 9);
      rd = $urandom_range(0, 15);
      r1 = $urandom_range(0, 15);
      r2 = $urandom_range(0, 15);
      f3 = $urandom_range(0, 7);
      k = $urandom_range(1, (76 - i) < 6 ? 76 - i : 6);
      imm = f3 == 1 ? $urandom_range(0, 31) :
            f3 == 5 ? $urandom_range(0, 31) + ($urandom_range(0, 1) ? 1024 : 0) : $urandom_range(0, 4095);
      case (c)
        0, 1: prog[i] = ei(imm, r1, f3, rd, 7'h13);
        2, 3: prog[i] = er(((f3 == 0 || f3 == 5) && $urandom_range(0, 1)) ? 32 : 0, r2, r1, f3, rd);
        4: prog[i] = {$urandom_range(0, 1048575) & 20'hfffff, 5'(rd), $urandom_range(0, 1) ? 7'h37 : 7'h17};
        5: prog[i] = ei(4 * $urandom_range(0, 15) + $urandom_range(0, 3), 0, 2, rd, 7'h03);
        6: prog[i] = es($urandom_range(0, 4095), r1, r2);
        7: prog[i] = eb(4 * k, r1, r2, bf[$urandom_range(0, 5)]);
        8: prog[i] = ej(4 * k, rd);
        default: prog[i] = ei(4 * (i + k), 0, 0, rd, 7'h67);
      endcase
    end
    prog[76] = ej(0, 0);
  endtask
  task automatic check_directed(string pfx);
    check({pfx, "_x0"}, dut.rf[0], 32'd0);
    check({pfx, "_x1"}, dut.rf[1], 32'd5);
    check({pfx, "_x2"}, dut.rf[2], 32'd12);
    check({pfx, "_x3_load"}, dut.rf[3], 32'd12);
    check({pfx, "_x4_loaduse"}, dut.rf[4], 32'd24);
    check({pfx, "_x5_flushed"}, dut.rf[5], 32'd0);
    check({pfx, "_x6_jal_link"}, dut.rf[6], 32'h24);
    check({pfx, "_x7_sub"}, dut.rf[7], 32'hFFFFFFFB);
    check({pfx, "_x8_srai"}, dut.rf[8], 32'hFFFFFFFD);
    check({pfx, "_x9_sltu"}, dut.rf[9], 32'd1);
    check({pfx, "_dmem0"}, dut.dmem[0], 32'd12);
  endtask
  initial begin
    reset = 1'b1;
    resetpc = 1'b0;
    we0 = 1'b0;
    wr_addr0 = '0;
    wr_din0 = '0;
    for (int i = 0; i < 128; i++) prog[i] = '0;
    tick(2);
    reset = 1'b0;
    prog[0]  = ei(5, 0, 0, 1, 7'h13);
    prog[1]  = ei(7, 1, 0, 2, 7'h13);
    prog[2]  = es(0, 0, 2);
    prog[3]  = ei(0, 0, 2, 3, 7'h03);
    prog[4]  = er(0, 3, 3, 0, 4);
    prog[5]  = eb(8, 1, 1, 0);
    prog[6]  = ei(1, 0, 0, 5, 7'h13);
    prog[7]  = eb(8, 1, 1, 1);
    prog[8]  = ej(8, 6);
    prog[9]  = ei(3, 0, 0, 5, 7'h13);
    prog[10] = ei(9, 0, 0, 0, 7'h13);
    prog[11] = er(32, 1, 0, 0, 7);
    prog[12] = ei(1024 + 1, 7, 5, 8, 7'h13);
    prog[13] = er(0, 7, 0, 3, 9);
    prog[14] = ej(0, 0);
    load(128);
    check("load_pc_held", dut.pc, 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("load_rf_x%0d", r), dut.rf[r], 32'd0);
    for (int i = 0; i < 15; i++) check($sformatf("load_imem_%0d", i), dut.imem[i], prog[i]);
    resetpc = 1'b1;
    tick(6);
    check("fwd_x1_6cyc", dut.rf[1], 32'd5);
    check("fwd_x2_6cyc", dut.rf[2], 32'd12);
    tick(30);
    check_directed("run1");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    resetpc = 1'b0;
    check("midreset_pc", dut.pc, 32'd0);
    tick(4);
    check("midreset_pc_held", dut.pc, 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("midreset_rf_x%0d", r), dut.rf[r], 32'd0);
    for (int i = 0; i < 15; i++) check($sformatf("midreset_imem_%0d", i), dut.imem[i], prog[i]);
    resetpc = 1'b1;
    tick(36);
    check_directed("rerun");
    for (int rnd = 0; rnd < 3; rnd++) begin
      gen();
      iss(76);
      reset = 1'b1;
      resetpc = 1'b0;
      tick(1);
      reset = 1'b0;
      load(77);
      for (int i = 0; i < 77; i++) check($sformatf("r%0d_imem_%0d", rnd, i), dut.imem[i], prog[i]);
      check($sformatf("r%0d_pc_held", rnd), dut.pc, 32'd0);
      resetpc = 1'b1;
      tick(400);
      for (int r = 0; r < 32; r++) check($sformatf("r%0d_x%0d", rnd, r), dut.rf[r], mrf[r]);
      for (int j = 0; j < 128; j++)
        if (known[j]) check($sformatf("r%0d_dmem_%0d", rnd, j), dut.dmem[j], mdm[j]);
      check($sformatf("r%0d_pc_halt", rnd), {31'b0, dut.pc >= 32'd304 && dut.pc <= 32'd312}, 32'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
